// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the FIFO adder datapath: state encodings, last-operand
// count and default data width, used by the sequencer and the output decoder.
package adder_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        OUT  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] COUNT_LAST = 2'b10;
    localparam int         DEF_DATA_W = 32;

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Bus between the adder sequencer and its environment (operand FIFO, control
// requests, and the state/count/result outputs feeding the output decoder).
interface adder_seq_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              op_start;
    logic              op_clear;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic [1:0]        state;
    logic [1:0]        count;
    logic [DATA_W-1:0] result;
    logic              op_err;
    logic              ovf;

    modport master (
        output op_start, op_clear, fifo_empty, fifo_dout,
        input  state, count, result, op_err, ovf
    );

    modport slave (
        input  op_start, op_clear, fifo_empty, fifo_dout,
        output state, count, result, op_err, ovf
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// State register, operand counter and accumulator for the FIFO adder datapath.
// Optional sticky carry-out flag is enabled by defining OVERFLOW_FLAG_EN.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TMO_MAX = 15
) (
    input logic            clk,
    input logic            reset_n,
    adder_seq_ctrl_if.slave bus
);

    localparam int              TMO_W    = $clog2(TMO_MAX + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        count_q;
    logic [DATA_W-1:0] result_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              op_err_q;
    logic              pop;
    logic              tmo_hit;
    logic [DATA_W:0]   sum;

    assign pop     = (state_q == EXEC) && (count_q != COUNT_LAST) && !bus.fifo_empty;
    assign tmo_hit = (state_q == EXEC) && (count_q != COUNT_LAST) && bus.fifo_empty
                     && (tmo_q == TMO_LAST);

`ifdef OVERFLOW_FLAG_EN
    assign sum = {1'b0, result_q} + {1'b0, bus.fifo_dout};
`else
    assign sum = {1'b0, result_q + bus.fifo_dout};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.op_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.op_start) state_d = EXEC;
                EXEC: begin
                    if (count_q == COUNT_LAST) state_d = OUT;
                    else if (tmo_hit)          state_d = DONE;
                end
                OUT:     state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Empty-FIFO cycles in EXEC only advance the timeout; the accumulator and
    // count move solely on an actual pop.
    always_ff @(posedge clk) begin
        if (!reset_n || bus.op_clear) begin
            count_q  <= 2'd0;
            result_q <= '0;
            tmo_q    <= '0;
            op_err_q <= 1'b0;
        end else if (state_q == IDLE && bus.op_start) begin
            count_q  <= 2'd0;
            result_q <= '0;
            tmo_q    <= '0;
            op_err_q <= 1'b0;
        end else if (pop) begin
            count_q  <= count_q + 2'd1;
            result_q <= sum[DATA_W-1:0];
            tmo_q    <= '0;
        end else if (tmo_hit) begin
            op_err_q <= 1'b1;
        end else if (state_q == EXEC && count_q != COUNT_LAST) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!reset_n || bus.op_clear) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && bus.op_start) begin
            ovf_q <= 1'b0;
        end else if (pop && sum[DATA_W]) begin
            ovf_q <= 1'b1;
        end
    end
`else
    logic ovf_q;
    logic unused_carry;

    assign ovf_q        = 1'b0;
    assign unused_carry = sum[DATA_W];
`endif

    always_comb begin
        bus.state  = state_q;
        bus.count  = count_q;
        bus.result = result_q;
        bus.op_err = op_err_q;
        bus.ovf    = ovf_q;
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl; honours OVERFLOW_FLAG_EN
// for the expected carry flag.
module tb_adder_seq_ctrl;

    localparam int DATA_W  = 32;
    localparam int TMO_MAX = 15;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_ovf;

    adder_seq_ctrl_if #(.DATA_W(DATA_W)) bus ();

    adder_seq_ctrl #(.DATA_W(DATA_W), .TMO_MAX(TMO_MAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic clear,
                                 input logic empty, input logic [31:0] dout);
        bus.op_start   = start;
        bus.op_clear   = clear;
        bus.fifo_empty = empty;
        bus.fifo_dout  = dout;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef OVERFLOW_FLAG_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        tick();
        checkOutput("rst_state", bus.state, 2'b00);
        checkOutput("rst_count", bus.count, 2'd0);
        checkOutput("rst_result", bus.result, 32'd0);
        checkOutput("rst_err", bus.op_err, 1'b0);
        checkOutput("rst_ovf", bus.ovf, 1'b0);
        reset_n = 1'b1;

        // Two operands 7 and 9, full latency sequence
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd7);
        tick();
        checkOutput("t2_s0", bus.state, 2'b01);
        checkOutput("t2_c0", bus.count, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd7);
        tick();
        checkOutput("t2_s1", bus.state, 2'b01);
        checkOutput("t2_c1", bus.count, 2'd1);
        checkOutput("t2_r1", bus.result, 32'd7);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd9);
        tick();
        checkOutput("t2_s2", bus.state, 2'b01);
        checkOutput("t2_c2", bus.count, 2'd2);
        checkOutput("t2_r2", bus.result, 32'd16);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        checkOutput("t2_s3", bus.state, 2'b10);
        tick();
        checkOutput("t2_s4", bus.state, 2'b11);
        tick();
        checkOutput("t2_s5", bus.state, 2'b00);
        checkOutput("t2_rhold", bus.result, 32'd16);

        // Reset in the middle of EXEC with count=1, result=5
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd5);
        tick();
        checkOutput("t1_c1", bus.count, 2'd1);
        checkOutput("t1_r5", bus.result, 32'd5);
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        checkOutput("t1_state", bus.state, 2'b00);
        checkOutput("t1_count", bus.count, 2'd0);
        checkOutput("t1_result", bus.result, 32'd0);
        reset_n = 1'b1;

        // FIFO empty for three cycles between the operands
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd7);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd7);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t3_hold%0d", i), bus.count, 2'd1);
            checkOutput($sformatf("t3_st%0d", i), bus.state, 2'b01);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd9);
        tick();
        checkOutput("t3_c2", bus.count, 2'd2);
        checkOutput("t3_r", bus.result, 32'd16);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        tick();
        tick();
        checkOutput("t3_idle", bus.state, 2'b00);
        checkOutput("t3_err", bus.op_err, 1'b0);

        // FIFO empty for the whole op: timeout after TMO_MAX EXEC cycles
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 1; i < TMO_MAX; i++) begin
            tick();
            checkOutput($sformatf("t4_exec%0d", i), bus.state, 2'b01);
        end
        tick();
        checkOutput("t4_done", bus.state, 2'b11);
        checkOutput("t4_err", bus.op_err, 1'b1);
        checkOutput("t4_result", bus.result, 32'd0);
        checkOutput("t4_count", bus.count, 2'd0);
        tick();
        checkOutput("t4_idle", bus.state, 2'b00);
        checkOutput("t4_sticky", bus.op_err, 1'b1);

        // Start and clear together in IDLE: clear wins
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd3);
        tick();
        checkOutput("t5_idle", bus.state, 2'b00);
        checkOutput("t5_errclr", bus.op_err, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd3);
        tick();
        checkOutput("t5_noop", bus.state, 2'b00);

        // Clear while in OUT
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        checkOutput("t5_out", bus.state, 2'b10);
        checkOutput("t5_r7", bus.result, 32'd7);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd0);
        tick();
        checkOutput("t5_clr_st", bus.state, 2'b00);
        checkOutput("t5_clr_r", bus.result, 32'd0);
        checkOutput("t5_clr_c", bus.count, 2'd0);

        // Wrap-around sum; start requests outside IDLE are ignored
        applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0002);
        tick();
        checkOutput("t6_result", bus.result, 32'h0000_0001);
        checkOutput("t6_ovf", bus.ovf, exp_ovf);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
        tick();
        checkOutput("t6_out", bus.state, 2'b10);
        tick();
        checkOutput("t6_done", bus.state, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        checkOutput("t6_idle", bus.state, 2'b00);
        tick();
        checkOutput("t6_noqueue", bus.state, 2'b00);
        checkOutput("t6_sticky", bus.ovf, exp_ovf);
        checkOutput("t6_rhold", bus.result, 32'h0000_0001);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd0);
        tick();
        checkOutput("t6_ovfclr", bus.ovf, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
